// File: rtl/score_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : score_packer_pkg
//  Brief    : Shared defaults, FSM state encoding and the saturate helper
//             used by the score packer and its saturating adder.
//  Revision : 1.0 - initial release
// ============================================================================
package score_packer_pkg;

   // Default geometry of one classifier output frame
   localparam int c_DEF_DATA_WIDTH = 28;
   localparam int c_DEF_NUM_CLASS  = 10;
   localparam int c_DEF_PARTS      = 4;

   // FSM state enumeration (explicit 2-bit encoding)
   localparam int         c_ST_W        = 2;
   localparam logic [1:0] c_ST_COLLECT   = 2'd0;
   localparam logic [1:0] c_ST_ISSUE     = 2'd1;
   localparam logic [1:0] c_ST_WAIT_DONE = 2'd2;

   // Clamp a signed value into the range of a w-bit two's-complement number.
   // Works on a 64-bit container so callers of any width below 64 can share it.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int                 w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end else begin
         return v;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/score_packer_sat_add.sv
`default_nettype none
// ============================================================================
//  Module   : sat_add
//  Brief    : Combinational signed adder whose result is clamped to OUT_W
//             bits. The sum is formed one bit wider than the inputs so it
//             can never wrap before the clamp is applied.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_add
   import score_packer_pkg::*;
#(
   parameter int IN_W  = 30,
   parameter int OUT_W = 28
) (
   input  logic signed [IN_W-1:0]  a_i,
   input  logic signed [IN_W-1:0]  b_i,
   output logic signed [OUT_W-1:0] sum_o
);

   logic signed [IN_W:0] w_sum;
   logic signed [63:0]   w_wide;
   logic signed [63:0]   w_sat;
   logic                 w_unused_hi;

   // Full-precision sum, widened to the helper's container, then clamped
   assign w_sum       = (IN_W + 1)'(a_i) + (IN_W + 1)'(b_i);
   assign w_wide      = 64'(w_sum);
   assign w_sat       = saturate(w_wide, OUT_W);
   assign sum_o       = w_sat[OUT_W-1:0];
   // After clamping the upper bits only replicate the sign; they carry no data
   assign w_unused_hi = ^w_sat[63:OUT_W];

endmodule
`default_nettype wire

// File: rtl/score_packer.sv
`default_nettype none
// ============================================================================
//  Module   : score_packer
//  Brief    : Accumulates PARTS partial-sum beats per class, saturates each
//             class score to DATA_WIDTH bits and packs NUM_CLASS scores into
//             one wide word. The frame is presented with a one-cycle valid and
//             held until the downstream argmax comparator signals done.
//  Revision : 1.0 - initial release
// ============================================================================
module score_packer
   import score_packer_pkg::*;
#(
   parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
   parameter int NUM_CLASS  = c_DEF_NUM_CLASS,
   parameter int PARTS      = c_DEF_PARTS        // legal range 1..16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic signed [DATA_WIDTH-1:0]     s_data,
   input  logic                             s_last,
   output logic [DATA_WIDTH*NUM_CLASS-1:0]  layer_out,
   output logic                             valid,
   input  logic                             done,
   output logic                             frame_err
);

   // Accumulator holds up to PARTS sign-extended beats without wrapping
   localparam int c_AW  = DATA_WIDTH + $clog2(PARTS);
   localparam int c_PCW = (PARTS > 1) ? $clog2(PARTS) : 1;
   localparam int c_CCW = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;

   logic [c_ST_W-1:0]       state_q, state_d;
   logic [c_PCW-1:0]        part_q, part_d;
   logic [c_CCW-1:0]        class_q, class_d;
   logic signed [c_AW-1:0]  acc_q, acc_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   slot_q [NUM_CLASS];

   logic                    w_accept;
   logic                    w_last_part;
   logic                    w_last_class;
   logic                    w_final;
   logic                    w_slot_we;
   logic signed [c_AW-1:0]  w_ext;
   logic signed [DATA_WIDTH-1:0] w_sat;

   assign s_ready      = (state_q == c_ST_COLLECT);
   assign valid        = (state_q == c_ST_ISSUE);
   assign frame_err    = err_q;

   assign w_accept     = s_valid && s_ready;
   assign w_last_part  = (part_q == c_PCW'(PARTS - 1));
   assign w_last_class = (class_q == c_CCW'(NUM_CLASS - 1));
   assign w_final      = w_last_part && w_last_class;
   assign w_ext        = c_AW'(s_data);

   // Class score = running partial sum plus the final beat, clamped
   sat_add #(
      .IN_W  (c_AW),
      .OUT_W (DATA_WIDTH)
   ) u_sat_add (
      .a_i   (acc_q),
      .b_i   (w_ext),
      .sum_o (w_sat)
   );

   // Next-state logic: beat bookkeeping, framing checks and issue handshake
   always_comb begin
      state_d   = state_q;
      part_d    = part_q;
      class_d   = class_q;
      acc_d     = acc_q;
      err_d     = 1'b0;
      w_slot_we = 1'b0;
      case (state_q)
         c_ST_COLLECT: begin
            if (w_accept) begin
               if (s_last && !w_final) begin
                  // Early s_last: abandon the partial frame and restart
                  err_d   = 1'b1;
                  part_d  = '0;
                  class_d = '0;
                  acc_d   = '0;
               end else if (w_last_part) begin
                  w_slot_we = 1'b1;
                  acc_d     = '0;
                  part_d    = '0;
                  if (w_last_class) begin
                     // Missing s_last is flagged but the frame is still issued
                     class_d = '0;
                     state_d = c_ST_ISSUE;
                     err_d   = !s_last;
                  end else begin
                     class_d = class_q + 1'b1;
                  end
               end else begin
                  acc_d  = acc_q + w_ext;
                  part_d = part_q + 1'b1;
               end
            end
         end
         c_ST_ISSUE: begin
            state_d = c_ST_WAIT_DONE;
         end
         c_ST_WAIT_DONE: begin
            if (done) begin
               state_d = c_ST_COLLECT;
            end
         end
         default: begin
            state_d = c_ST_COLLECT;
         end
      endcase
   end

   // Control and accumulator registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_ST_COLLECT;
         part_q  <= '0;
         class_q <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         part_q  <= part_d;
         class_q <= class_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
      end
   end

   // Score slots: only the completing class is written, others keep their value
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CLASS; k++) begin
            slot_q[k] <= '0;
         end
      end else if (w_slot_we) begin
         slot_q[class_q] <= w_sat;
      end
   end

   generate
      for (genvar k = 0; k < NUM_CLASS; k++) begin : g_pack
         assign layer_out[DATA_WIDTH*k +: DATA_WIDTH] = slot_q[k];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_score_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_packer
//  Brief    : Directed self-checking bench for score_packer (default geometry:
//             28-bit scores, 10 classes, 4 parts per class).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_packer;

   localparam int DW = 28;
   localparam int NC = 10;
   localparam int P  = 4;
   localparam int LW = DW * NC;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_last;
   logic          done;
   logic [DW-1:0] s_data;
   wire           s_ready;
   wire           valid;
   wire           frame_err;
   wire  [LW-1:0] layer_out;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   score_packer #(
      .DATA_WIDTH (DW),
      .NUM_CLASS  (NC),
      .PARTS      (P)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .layer_out (layer_out),
      .valid     (valid),
      .done      (done),
      .frame_err (frame_err)
   );

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Per-beat data: kind 0 = all ones, kind 2 = all threes, kind 1 = mixed/boundary
   function automatic logic [DW-1:0] cdata(input int kind, input int c);
      if (kind == 0) return 28'd1;
      if (kind == 2) return 28'd3;
      case (c)
         0: return 28'hFFFFFFF;   // -1
         3: return 28'h7FFFFFF;   // max positive
         5: return 28'h8000000;   // max negative
         8: return 28'h2000000;   // 4x lands one above max
         9: return 28'h1FFFFFF;   // 4x lands just below max
         default: return DW'(c);
      endcase
   endfunction

   // Hand-computed slot value after four identical beats of cdata(kind, c)
   function automatic logic [DW-1:0] cexp(input int kind, input int c);
      if (kind == 0) return 28'd4;
      if (kind == 2) return 28'd12;
      case (c)
         0: return 28'hFFFFFFC;
         3: return 28'h7FFFFFF;
         5: return 28'h8000000;
         8: return 28'h7FFFFFF;
         9: return 28'h7FFFFFC;
         default: return DW'(4 * c);
      endcase
   endfunction

   function automatic logic [LW-1:0] fexp(input int kind);
      logic [LW-1:0] r;
      r = '0;
      for (int c = 0; c < NC; c++) r[c*DW +: DW] = cexp(kind, c);
      return r;
   endfunction

   // Present one beat at a negedge and return at the negedge after it is accepted
   task automatic beat(input logic [DW-1:0] d, input logic l);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (s_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         tests++;
         fails++;
         $display("FAIL beat_timeout s_ready stayed %b, required 1", s_ready);
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Beats from..to-1 (0-based); s_last goes on 1-based beat lastidx (0 = none)
   task automatic send(input int kind, input int from, input int to, input int lastidx);
      for (int i = from; i < to; i++) begin
         beat(cdata(kind, i / P), (i + 1) == lastidx);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      done    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ready", LW'(s_ready), LW'(1'b1));
      chk("reset_valid", LW'(valid), LW'(1'b0));
      chk("reset_err", LW'(frame_err), LW'(1'b0));
      chk("reset_layer", layer_out, '0);

      // Frame A: all ones, s_last on beat 40
      send(0, 0, 40, 40);
      chk("A_valid", LW'(valid), LW'(1'b1));
      chk("A_err", LW'(frame_err), LW'(1'b0));
      chk("A_layer", layer_out, fexp(0));
      @(negedge clk);
      chk("A_valid_pulse", LW'(valid), LW'(1'b0));
      chk("A_wait_ready", LW'(s_ready), LW'(1'b0));
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("A_ready_back", LW'(s_ready), LW'(1'b1));

      // Frame B: clamp boundaries, then done held low with upstream pushing
      send(1, 0, 40, 40);
      chk("B_valid", LW'(valid), LW'(1'b1));
      chk("B_err", LW'(frame_err), LW'(1'b0));
      chk("B_layer", layer_out, fexp(1));
      s_valid = 1'b1;
      s_data  = cdata(2, 0);
      s_last  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_ready", LW'(s_ready), LW'(1'b0));
         chk("hold_valid", LW'(valid), LW'(1'b0));
         chk("hold_layer", layer_out, fexp(1));
      end
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("resume_ready", LW'(s_ready), LW'(1'b1));
      @(negedge clk);   // held beat is taken as beat 1 of frame C

      // Frame C: remaining 39 beats
      send(2, 1, 40, 40);
      chk("C_valid", LW'(valid), LW'(1'b1));
      chk("C_layer", layer_out, fexp(2));
      chk("C_err", LW'(frame_err), LW'(1'b0));
      done = 1'b1;
      @(negedge clk);
      chk("C_wait_ready", LW'(s_ready), LW'(1'b0));
      @(negedge clk);
      done = 1'b0;
      chk("C_ready_back", LW'(s_ready), LW'(1'b1));

      // Early s_last on beat 17; same data as frame C so slots match either way
      send(2, 0, 17, 17);
      chk("E_err", LW'(frame_err), LW'(1'b1));
      chk("E_valid", LW'(valid), LW'(1'b0));
      chk("E_ready", LW'(s_ready), LW'(1'b1));
      chk("E_layer", layer_out, fexp(2));
      @(negedge clk);
      chk("E_err_pulse", LW'(frame_err), LW'(1'b0));

      // Clean frame after the drop, with done held high (ignored in COLLECT)
      done = 1'b1;
      send(0, 0, 40, 40);
      chk("D_valid", LW'(valid), LW'(1'b1));
      chk("D_layer", layer_out, fexp(0));
      chk("D_err", LW'(frame_err), LW'(1'b0));
      @(negedge clk);
      chk("D_wait_ready", LW'(s_ready), LW'(1'b0));
      @(negedge clk);
      done = 1'b0;
      chk("D_ready_back", LW'(s_ready), LW'(1'b1));

      // Final beat without s_last: flagged but still issued
      send(1, 0, 40, 0);
      chk("M_valid", LW'(valid), LW'(1'b1));
      chk("M_err", LW'(frame_err), LW'(1'b1));
      chk("M_layer", layer_out, fexp(1));
      @(negedge clk);
      chk("M_err_pulse", LW'(frame_err), LW'(1'b0));
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;

      // Reset after beat 25
      send(0, 0, 25, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("R_layer", layer_out, '0);
      chk("R_ready", LW'(s_ready), LW'(1'b1));
      chk("R_valid", LW'(valid), LW'(1'b0));
      repeat (5) @(negedge clk);
      chk("R_no_valid", LW'(valid), LW'(1'b0));
      send(2, 0, 40, 40);
      chk("R2_valid", LW'(valid), LW'(1'b1));
      chk("R2_layer", layer_out, fexp(2));

      // Reset while waiting for done
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("W_ready", LW'(s_ready), LW'(1'b1));
      chk("W_layer", layer_out, '0);
      chk("W_valid", LW'(valid), LW'(1'b0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
